mini_alu_seq: RTL and testbench
===============================

MINI_ALU_SEQ -- requirements
Module: mini_alu_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width.
REQ-002 Parameter SETTLE_CYCLES, default 1, minimum 1: cycles alu_a/alu_b/alu_sel are held before alu_y is sampled.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_a, cmd_b  input  WIDTH  operands.
REQ-008 cmd_sel  input  2  op select: 00 AND, 01 OR, 10 ADD, 11 SUB.
REQ-009 alu_a, alu_b  output  WIDTH  registered operands driven to the combinational ALU.
REQ-010 alu_sel  output  2  registered op select driven to the ALU.
REQ-011 alu_y  input  WIDTH  ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_y  output  WIDTH  captured ALU result.
REQ-015 rsp_mismatch  output  1  captured result differs from internal expected value.
REQ-016 err_count  output  8  saturating mismatch counter.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM has four states: IDLE, SETTLE, CAPTURE, RESP.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, latch cmd_a/cmd_b/cmd_sel into alu_a/alu_b/alu_sel, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-020 cmd_ready is 0 in every state other than IDLE; a command is transferred only on a cycle where cmd_valid and cmd_ready are both 1.
REQ-021 SETTLE: decrement counter each cycle; when counter is 0, go to CAPTURE.
REQ-022 CAPTURE: register alu_y into rsp_y, register rsp_mismatch, update err_count, go to RESP.
REQ-023 RESP: rsp_valid=1; rsp_y and rsp_mismatch held stable until rsp_valid and rsp_ready are both 1, then go to IDLE.
REQ-024 Latency: command accepted at edge N -> rsp_valid high after edge N+SETTLE_CYCLES+1 (N+2 at default).
REQ-025 alu_a/alu_b/alu_sel change only on command acceptance; held through SETTLE, CAPTURE and RESP.
REQ-026 Expected value: AND and OR bitwise; ADD is (a+b) mod 2^WIDTH with carry discarded; SUB is (a-b) mod 2^WIDTH, two's complement wrap.
REQ-027 err_count increments by 1 on each CAPTURE with mismatch and saturates at 255.
REQ-028 Back-to-back: with rsp_ready held 1, RESP->IDLE takes one cycle, so cmd_ready is 1 on the cycle after the response handshake.
REQ-029 cmd_valid while busy is ignored; the command is neither latched nor lost from the producer's view, since the producer holds cmd_valid until cmd_ready.

Reset
REQ-030 rst asserted at any time, including mid-operation: state goes to IDLE immediately and any in-flight command is discarded.
REQ-031 Reset values: cmd_ready=1 once rst is released; rsp_valid=0, rsp_y=0, rsp_mismatch=0, err_count=0, busy=0, alu_a=0, alu_b=0, alu_sel=00.

Configuration
REQ-032 Macro MINI_ALU_SEQ_SELFCHECK_EN defined: internal expected-value model, rsp_mismatch and err_count are active as in REQ-022 and REQ-026/027.
REQ-033 Macro undefined: no expected-value logic; rsp_mismatch is constant 0 and err_count is constant 0; all handshake timing is unchanged.

Verification
REQ-034 With a correct ALU, send AND 1100,1010 then OR 1100,1010 -> rsp_y=1000 then 1110, rsp_mismatch=0, each rsp_valid 2 cycles after acceptance.
REQ-035 Send ADD 0011,0101, then ADD 1111,0001, then SUB 0110,0011, then SUB 0000,0001 -> rsp_y=1000, 0000, 0011, 1111 respectively, no mismatch.
REQ-036 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_y stable, cmd_ready=0 throughout, second command accepted only after the response handshake.
REQ-037 With SELFCHECK_EN, force alu_y=0000 on ADD 0011,0101 -> rsp_mismatch=1, err_count=1; repeat 300 times -> err_count=255.
REQ-038 Assert rst during SETTLE -> busy=0, rsp_valid=0, err_count=0 immediately; the next command completes normally.
REQ-039 SETTLE_CYCLES=3 -> rsp_valid high 4 cycles after acceptance; alu_a/alu_b/alu_sel constant over that window.

Source files
------------

// File: rtl/mini_alu_seq.sv
// Sequencer that drives registered operands into an external combinational ALU and captures its result.
// Optional result self-check against an internal model is enabled by defining MINI_ALU_SEQ_SELFCHECK_EN.
module mini_alu_seq #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_mismatch,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETTLE  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands only move on acceptance, so the ALU inputs stay put until the response is consumed.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        cnt_d     = cnt_q;
        rsp_y_d   = rsp_y_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    cnt_d     = CNT_INIT;
                end
            end
            SETTLE:  if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            CAPTURE: rsp_y_d = alu_y;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= 2'b00;
            cnt_q     <= '0;
            rsp_y_q   <= '0;
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            cnt_q     <= cnt_d;
            rsp_y_q   <= rsp_y_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign rsp_y   = rsp_y_q;

`ifdef MINI_ALU_SEQ_SELFCHECK_EN
    function automatic logic [WIDTH-1:0] alu_model(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] y;
        case (sel)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a + b;
            default: y = a - b;
        endcase
        return y;
    endfunction

    logic       mism_q, mism_d;
    logic [7:0] err_q, err_d;

    always_comb begin
        mism_d = mism_q;
        err_d  = err_q;
        if (state_q == CAPTURE) begin
            mism_d = (alu_y != alu_model(alu_a_q, alu_b_q, alu_sel_q));
            if (mism_d && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mism_q <= 1'b0;
            err_q  <= 8'd0;
        end else begin
            mism_q <= mism_d;
            err_q  <= err_d;
        end
    end

    assign rsp_mismatch = mism_q;
    assign err_count    = err_q;
`else
    assign rsp_mismatch = 1'b0;
    assign err_count    = 8'd0;
`endif

endmodule

// File: tb/tb_mini_alu_seq.sv
// Directed bench for mini_alu_seq: a behavioural ALU drives alu_y, expected responses go through a queue.
module tb_mini_alu_seq;

`ifdef MINI_ALU_SEQ_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    typedef struct {
        logic [3:0] y;
        logic       mm;
        logic [7:0] ec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [1:0] cmd_sel = '0;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [1:0] alu_sel;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [3:0] rsp_y;
    logic       rsp_mismatch, busy;
    logic [7:0] err_count;
    logic       fault = 1'b0;

    logic       c3_valid = 1'b0, c3_ready;
    logic [3:0] c3_a = '0, c3_b = '0;
    logic [1:0] c3_sel = '0;
    logic [3:0] c3_alu_a, c3_alu_b, c3_alu_y;
    logic [1:0] c3_alu_sel;
    logic       c3_rsp_valid;
    logic [3:0] c3_rsp_y;
    logic       c3_mm, c3_busy;
    logic [7:0] c3_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   err_exp = 0;

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
        logic [4:0] s;
        case (sel)
            2'b00:   s = {1'b0, a & b};
            2'b01:   s = {1'b0, a | b};
            2'b10:   s = {1'b0, a} + {1'b0, b};
            default: s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        endcase
        return s[3:0];
    endfunction

    assign alu_y    = fault ? 4'b0000 : ref_alu(alu_a, alu_b, alu_sel);
    assign c3_alu_y = ref_alu(c3_alu_a, c3_alu_b, c3_alu_sel);

    mini_alu_seq #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_mismatch(rsp_mismatch), .err_count(err_count), .busy(busy)
    );

    mini_alu_seq #(.WIDTH(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_a(c3_a), .cmd_b(c3_b), .cmd_sel(c3_sel),
        .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_sel(c3_alu_sel), .alu_y(c3_alu_y),
        .rsp_valid(c3_rsp_valid), .rsp_ready(1'b1), .rsp_y(c3_rsp_y),
        .rsp_mismatch(c3_mm), .err_count(c3_err), .busy(c3_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel, input bit flt);
        exp_t e;
        logic [3:0] r;
        r    = ref_alu(a, b, sel);
        e.y  = flt ? 4'b0000 : r;
        e.mm = SC && (e.y != r);
        if (e.mm && err_exp < 255) err_exp++;
        e.ec = 8'(err_exp);
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge just after the acceptance edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel, input bit flt);
        int n = 0;
        push(a, b, sel, flt);
        fault     = flt;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int   lat = 0;
        exp_t e;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_y", 32'(rsp_y), 32'(e.y));
            chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mm));
            chk("err_count", 32'(err_count), 32'(e.ec));
        end
        fault = 1'b0;
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel, input bit flt);
        issue(a, b, sel, flt);
        wait_rsp();
        finish_rsp();
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_mismatch", 32'(rsp_mismatch), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        txn(4'b1100, 4'b1010, 2'b00, 1'b0);
        txn(4'b1100, 4'b1010, 2'b01, 1'b0);
        txn(4'b0011, 4'b0101, 2'b10, 1'b0);
        txn(4'b1111, 4'b0001, 2'b10, 1'b0);
        txn(4'b0110, 4'b0011, 2'b11, 1'b0);
        txn(4'b0000, 4'b0001, 2'b11, 1'b0);

        // Response stalled while the next command waits
        rsp_ready = 1'b0;
        issue(4'b0101, 4'b0011, 2'b10, 1'b0);
        wait_rsp();
        push(4'b1001, 4'b0110, 2'b01, 1'b0);
        cmd_a     = 4'b1001;
        cmd_b     = 4'b0110;
        cmd_sel   = 2'b01;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_y", 32'(rsp_y), 32'b1000);
            chk("hold_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({4'b0101, 4'b0011, 2'b10}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_hs_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({4'b0101, 4'b0011, 2'b10}));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("second_latched", 32'({alu_a, alu_b, alu_sel}), 32'({4'b1001, 4'b0110, 2'b01}));
        wait_rsp();
        finish_rsp();

        // Faulty ALU: 300 wrong results, counter must saturate
        txn(4'b0011, 4'b0101, 2'b10, 1'b1);
        for (int i = 1; i < 300; i++) txn(4'b0011, 4'b0101, 2'b10, 1'b1);
        chk("err_saturated", 32'(err_count), SC ? 32'd255 : 32'd0);
        txn(4'b0011, 4'b0101, 2'b10, 1'b0);
        chk("err_after_good", 32'(err_count), SC ? 32'd255 : 32'd0);

        // Reset while SETTLE
        issue(4'b0011, 4'b0101, 2'b10, 1'b1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        exp_q.delete();
        err_exp = 0;
        fault   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
        txn(4'b1010, 4'b0111, 2'b11, 1'b0);

        // SETTLE_CYCLES = 3 instance
        c3_a     = 4'b0110;
        c3_b     = 4'b0011;
        c3_sel   = 2'b11;
        c3_valid = 1'b1;
        chk("c3_cmd_ready", 32'(c3_ready), 32'd1);
        @(negedge clk);
        c3_valid = 1'b0;
        lat = 0;
        while (!c3_rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            chk("c3_alu_hold", 32'({c3_alu_a, c3_alu_b, c3_alu_sel}), 32'({4'b0110, 4'b0011, 2'b11}));
        end
        chk("c3_latency", 32'(lat), 32'd4);
        chk("c3_rsp_y", 32'(c3_rsp_y), 32'b0011);
        chk("c3_mismatch", 32'(c3_mm), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
